interrupt_sequencer: RTL and testbench
======================================

INTERRUPT_SEQUENCER -- requirements
Module: interrupt_sequencer

Interface
REQ-001 No parameters; 8 interrupt levels (IR0-IR7), fixed.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 irq_in  in  8  raw interrupt request lines, already synchronized to clk.
REQ-005 level_edge_triggered  in  1  1 = level mode, 0 = edge mode.
REQ-006 int_mask  in  8  1 = level masked.
REQ-007 priority_rotate  in  3  lowest-priority level; 3'b111 = IR0 highest.
REQ-008 eoi  in  8  one-hot/multi-hot ISR clear request, sampled every cycle.
REQ-009 auto_eoi  in  1  1 = clear ISR bit at end of acknowledge sequence.
REQ-010 vector_base  in  5  vector bits T7-T3.
REQ-011 int_ack  in  1  active-high acknowledge level from bus, synchronized to clk.
REQ-012 INT  out  1  interrupt request to CPU.
REQ-013 vector_out  out  8  {vector_base, level}.
REQ-014 vector_valid  out  1  vector_out valid for the bus.
REQ-015 irr  out  8  interrupt request register.
REQ-016 isr  out  8  in-service register.
REQ-017 highest_level_in_service  out  8  one-hot highest-priority ISR bit, 0 if ISR empty.

Function
REQ-018 Priority order: level (priority_rotate+1) mod 8 highest, descending modulo 8; priority_rotate lowest.
REQ-019 Edge mode: irr[i] set on cycle after irq_in[i] 0->1 (registered previous value); level mode: irr[i] = irq_in[i] registered each cycle.
REQ-020 Edge-mode irr[i] cleared when level i is latched at ACK1 entry; set has priority over clear if a new edge arrives that same cycle.
REQ-021 INT asserted (registered, 1-cycle latency) when highest-priority unmasked irr bit outranks highest isr bit, or isr empty; deasserted otherwise.
REQ-022 FSM states IDLE, ACK1, ACK2; transitions on int_ack rising edge (int_ack high, previous low).
REQ-023 IDLE -> ACK1 on int_ack rise: winning unmasked irr level frozen into ack_level, isr[ack_level] set; if no eligible request, ack_level = 7, isr unchanged (spurious).
REQ-024 ACK1 -> ACK2 on second int_ack rise; vector_out = {vector_base, ack_level}, vector_valid = 1 while in ACK2 and int_ack high.
REQ-025 ACK2 -> IDLE on int_ack falling edge; if auto_eoi and not spurious, isr[ack_level] cleared that cycle.
REQ-026 INT forced 0 in ACK1 and ACK2; re-evaluated from IDLE.
REQ-027 isr &= ~eoi every cycle; simultaneous eoi and ACK1 set on same bit: set wins.
REQ-028 int_ack rise in ACK2 ignored; int_ack fall in IDLE/ACK1 ignored.
REQ-029 vector_out = 8'h00 and vector_valid = 0 outside ACK2.

Reset
REQ-030 reset: state IDLE, irr = 0, isr = 0, irq_in history = 0, ack_level = 0, INT = 0, vector_out = 0, vector_valid = 0.
REQ-031 reset mid-sequence abandons it; no ISR bit remains set.

Structure
REQ-032 Package pic_pkg holds: FSM state enum, NUM_IR = 8, DEFAULT_ROTATE = 3'b111, SPURIOUS_LEVEL = 3'd7.
REQ-033 Combinational sub-module priority_resolver: (request vector, priority_rotate) -> one-hot winner plus 3-bit index; instanced twice (irr and isr).

Verification
REQ-034 Edge mode, mask 0, rotate 7, base 5'h08: irq_in[3] rises -> INT next cycle; two int_ack pulses -> isr=8'h08, vector_out=8'h43, irr[3]=0.
REQ-035 irr=8'h24, rotate 3'd4: winner IR5 -> vector low bits 3'd5, isr=8'h20.
REQ-036 isr=8'h02, irq on IR4, rotate 7 -> INT stays 0; eoi=8'h02 -> INT asserts one cycle later.
REQ-037 auto_eoi=1, IR0 ack -> isr[0] set during sequence, 0 after int_ack final fall.
REQ-038 int_ack pulses with all masked -> vector low bits 3'd7, isr stays 8'h00.
REQ-039 reset asserted in ACK1 -> next cycle state IDLE, isr=0, INT=0, vector_valid=0.

Source files
------------

// File: rtl/pic_pkg.sv
// Shared types and constants for the 8-level interrupt sequencer.
package pic_pkg;

    localparam int NUM_IR = 8;
    localparam logic [2:0] DEFAULT_ROTATE = 3'b111;
    localparam logic [2:0] SPURIOUS_LEVEL = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACK1,
        S_ACK2
    } state_t;

    // Rank 0 is the highest priority under the given rotation.
    function automatic logic [2:0] rank_of(
        input logic [2:0] lvl,
        input logic [2:0] rot
    );
        return lvl - rot - 3'd1;
    endfunction

endpackage

// File: rtl/priority_resolver.sv
// Rotating-priority picker: highest-ranked set bit of req.
module priority_resolver
    import pic_pkg::*;
(
    input  logic [NUM_IR-1:0] req,
    input  logic [2:0]        rotate,
    output logic [NUM_IR-1:0] onehot,
    output logic [2:0]        idx,
    output logic              any
);

    logic [2:0] lvl;

    always_comb begin
        idx    = '0;
        any    = 1'b0;
        lvl    = '0;
        // Scan lowest to highest priority so the last hit wins.
        for (int k = NUM_IR - 1; k >= 0; k--) begin
            lvl = rotate + 3'd1 + 3'(k);
            if (req[lvl]) begin
                idx = lvl;
                any = 1'b1;
            end
        end
        onehot = any ? (8'b1 << idx) : 8'b0;
    end

endmodule

// File: rtl/interrupt_sequencer.sv
// 8-level interrupt sequencer: request/in-service tracking and
// a two-pulse acknowledge handshake delivering an 8-bit vector.
module interrupt_sequencer
    import pic_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_IR-1:0] irq_in,
    input  logic              level_edge_triggered,
    input  logic [NUM_IR-1:0] int_mask,
    input  logic [2:0]        priority_rotate,
    input  logic [NUM_IR-1:0] eoi,
    input  logic              auto_eoi,
    input  logic [4:0]        vector_base,
    input  logic              int_ack,
    output logic              INT,
    output logic [7:0]        vector_out,
    output logic              vector_valid,
    output logic [NUM_IR-1:0] irr,
    output logic [NUM_IR-1:0] isr,
    output logic [NUM_IR-1:0] highest_level_in_service
);

    state_t            state;
    logic [NUM_IR-1:0] irq_prev;
    logic              ack_prev;
    logic [2:0]        ack_level;
    logic              spurious;

    logic [NUM_IR-1:0] win_oh;
    logic [2:0]        win_idx;
    logic              win_any;
    logic [2:0]        isr_idx;
    logic              isr_any;

    logic              ack_rise;
    logic              ack_fall;
    logic              enter;
    logic              to_ack2;
    logic              leave;
    logic              int_cond;
    logic [NUM_IR-1:0] irr_n;
    logic [NUM_IR-1:0] isr_n;

    priority_resolver u_irr_pick (
        .req    (irr & ~int_mask),
        .rotate (priority_rotate),
        .onehot (win_oh),
        .idx    (win_idx),
        .any    (win_any)
    );

    priority_resolver u_isr_pick (
        .req    (isr),
        .rotate (priority_rotate),
        .onehot (highest_level_in_service),
        .idx    (isr_idx),
        .any    (isr_any)
    );

    always_comb begin
        ack_rise = int_ack & ~ack_prev;
        ack_fall = ~int_ack & ack_prev;
        enter    = (state == S_IDLE) && ack_rise;
        to_ack2  = (state == S_ACK1) && ack_rise;
        leave    = (state == S_ACK2) && ack_fall;
        int_cond = win_any && (!isr_any ||
                   rank_of(win_idx, priority_rotate) <
                   rank_of(isr_idx, priority_rotate));

        // A fresh edge in the latch cycle re-arms the request.
        if (level_edge_triggered)
            irr_n = irq_in;
        else
            irr_n = (irr & ~((enter && win_any) ? win_oh : 8'h00))
                  | (irq_in & ~irq_prev);

        isr_n = isr & ~eoi;
        if (enter && win_any)
            isr_n[win_idx] = 1'b1;
        if (leave && auto_eoi && !spurious)
            isr_n[ack_level] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            irq_prev     <= '0;
            ack_prev     <= 1'b0;
            irr          <= '0;
            isr          <= '0;
            ack_level    <= '0;
            spurious     <= 1'b0;
            INT          <= 1'b0;
            vector_out   <= '0;
            vector_valid <= 1'b0;
        end else begin
            irq_prev <= irq_in;
            ack_prev <= int_ack;
            irr      <= irr_n;
            isr      <= isr_n;
            INT      <= (state == S_IDLE) && !enter && int_cond;

            unique case (state)
                S_IDLE: if (ack_rise) begin
                    state     <= S_ACK1;
                    ack_level <= win_any ? win_idx : SPURIOUS_LEVEL;
                    spurious  <= !win_any;
                end
                S_ACK1: if (ack_rise) state <= S_ACK2;
                S_ACK2: if (ack_fall) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase

            if (to_ack2 || (state == S_ACK2 && int_ack)) begin
                vector_valid <= 1'b1;
                vector_out   <= {vector_base, ack_level};
            end else begin
                vector_valid <= 1'b0;
                vector_out   <= 8'h00;
            end
        end
    end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed self-checking bench for interrupt_sequencer.
module tb_interrupt_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] irq_in;
    logic       level_edge_triggered;
    logic [7:0] int_mask;
    logic [2:0] priority_rotate;
    logic [7:0] eoi;
    logic       auto_eoi;
    logic [4:0] vector_base;
    logic       int_ack;
    logic       INT;
    logic [7:0] vector_out;
    logic       vector_valid;
    logic [7:0] irr;
    logic [7:0] isr;
    logic [7:0] highest_level_in_service;

    int checks = 0;
    int errors = 0;
    logic [7:0] vec;
    logic       vv;

    always #5 clk = ~clk;

    interrupt_sequencer dut (
        .clk                      (clk),
        .reset                    (reset),
        .irq_in                   (irq_in),
        .level_edge_triggered     (level_edge_triggered),
        .int_mask                 (int_mask),
        .priority_rotate          (priority_rotate),
        .eoi                      (eoi),
        .auto_eoi                 (auto_eoi),
        .vector_base              (vector_base),
        .int_ack                  (int_ack),
        .INT                      (INT),
        .vector_out               (vector_out),
        .vector_valid             (vector_valid),
        .irr                      (irr),
        .isr                      (isr),
        .highest_level_in_service (highest_level_in_service)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Two acknowledge pulses; captures the vector seen during the second.
    task automatic ack_cycle(output logic [7:0] v, output logic valid);
        int_ack = 1'b1; tick(); tick();
        int_ack = 1'b0; tick();
        int_ack = 1'b1; tick();
        v = vector_out;
        valid = vector_valid;
        int_ack = 1'b0; tick();
    endtask

    initial begin
        reset = 1'b1; irq_in = 8'h00; level_edge_triggered = 1'b0;
        int_mask = 8'h00; priority_rotate = 3'd7; eoi = 8'h00;
        auto_eoi = 1'b0; vector_base = 5'h08; int_ack = 1'b0;
        tick(); tick();
        chk("rst_int", {7'd0, INT}, 8'h00);
        chk("rst_irr", irr, 8'h00);
        chk("rst_isr", isr, 8'h00);
        chk("rst_vec", vector_out, 8'h00);
        chk("rst_vv", {7'd0, vector_valid}, 8'h00);
        chk("rst_hlis", highest_level_in_service, 8'h00);
        reset = 1'b0;
        tick();

        // IR3 edge, full manual handshake
        irq_in = 8'h08; tick();
        chk("e3_irr", irr, 8'h08);
        tick();
        chk("e3_int", {7'd0, INT}, 8'h01);
        int_ack = 1'b1; tick();
        chk("e3_isr", isr, 8'h08);
        chk("e3_irrclr", irr, 8'h00);
        chk("e3_int_ack1", {7'd0, INT}, 8'h00);
        chk("e3_vv_ack1", {7'd0, vector_valid}, 8'h00);
        tick();
        int_ack = 1'b0; tick(); tick();
        int_ack = 1'b1; tick();
        chk("e3_vec", vector_out, 8'h43);
        chk("e3_vv", {7'd0, vector_valid}, 8'h01);
        int_ack = 1'b0; tick();
        chk("e3_vec_idle", vector_out, 8'h00);
        chk("e3_vv_idle", {7'd0, vector_valid}, 8'h00);
        chk("e3_isr_keep", isr, 8'h08);
        chk("e3_hlis", highest_level_in_service, 8'h08);
        chk("e3_int_idle", {7'd0, INT}, 8'h00);
        eoi = 8'h08; tick(); eoi = 8'h00;
        chk("e3_eoi", isr, 8'h00);
        irq_in = 8'h00; tick();

        // Rotation 4: IR5 beats IR2
        irq_in = 8'h24; priority_rotate = 3'd4; tick();
        chk("r4_irr", irr, 8'h24);
        tick();
        ack_cycle(vec, vv);
        chk("r4_vec", vec, 8'h45);
        chk("r4_vv", {7'd0, vv}, 8'h01);
        chk("r4_isr", isr, 8'h20);
        chk("r4_irr_left", irr, 8'h04);
        eoi = 8'hff; tick(); eoi = 8'h00;
        ack_cycle(vec, vv);
        chk("r4_vec2", vec, 8'h42);
        eoi = 8'hff; tick(); eoi = 8'h00;
        irq_in = 8'h00; priority_rotate = 3'd7; tick();

        // In-service IR1 blocks IR4 until EOI
        irq_in = 8'h02; tick();
        ack_cycle(vec, vv);
        chk("n_vec1", vec, 8'h41);
        chk("n_isr1", isr, 8'h02);
        irq_in = 8'h12; tick();
        chk("n_irr4", irr, 8'h10);
        tick(); tick();
        chk("n_blocked", {7'd0, INT}, 8'h00);
        eoi = 8'h02; tick(); eoi = 8'h00;
        chk("n_isr_clr", isr, 8'h00);
        tick();
        chk("n_int_after_eoi", {7'd0, INT}, 8'h01);
        ack_cycle(vec, vv);
        chk("n_vec4", vec, 8'h44);
        chk("n_isr4", isr, 8'h10);
        eoi = 8'hff; tick(); eoi = 8'h00;
        irq_in = 8'h00; tick();

        // Auto-EOI on IR0
        auto_eoi = 1'b1;
        irq_in = 8'h01; tick(); tick();
        int_ack = 1'b1; tick();
        chk("a_isr_set", isr, 8'h01);
        tick();
        int_ack = 1'b0; tick();
        int_ack = 1'b1; tick();
        chk("a_vec", vector_out, 8'h40);
        chk("a_isr_mid", isr, 8'h01);
        int_ack = 1'b0; tick();
        chk("a_isr_clr", isr, 8'h00);
        auto_eoi = 1'b0; irq_in = 8'h00; tick();

        // All masked: spurious acknowledge
        int_mask = 8'hff;
        irq_in = 8'h04; tick();
        chk("s_irr", irr, 8'h04);
        tick();
        chk("s_int", {7'd0, INT}, 8'h00);
        ack_cycle(vec, vv);
        chk("s_vec", vec, 8'h47);
        chk("s_isr", isr, 8'h00);
        int_mask = 8'h00;

        // Level mode follows irq_in
        level_edge_triggered = 1'b1;
        irq_in = 8'h00; tick();
        chk("l_irr0", irr, 8'h00);
        irq_in = 8'h80; tick();
        chk("l_irr1", irr, 8'h80);
        irq_in = 8'h00; tick();
        chk("l_irr2", irr, 8'h00);
        level_edge_triggered = 1'b0; tick();

        // Reset in ACK1
        irq_in = 8'h40; tick(); tick();
        chk("x_int", {7'd0, INT}, 8'h01);
        int_ack = 1'b1; tick();
        chk("x_isr_ack1", isr, 8'h40);
        reset = 1'b1; int_ack = 1'b0; tick();
        chk("x_isr", isr, 8'h00);
        chk("x_int0", {7'd0, INT}, 8'h00);
        chk("x_vv", {7'd0, vector_valid}, 8'h00);
        chk("x_irr", irr, 8'h00);
        reset = 1'b0; tick();
        chk("x_irr_re", irr, 8'h40);
        tick();
        chk("x_int_idle", {7'd0, INT}, 8'h01);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
